// File: rtl/alb_nibble_sequencer.sv
// Multi-nibble initiator for the 4-bit ALB: issues one wide operation LSB nibble first,
// chains carry between nibbles and folds the per-nibble flags into whole-word flags.
module alb_nibble_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   START,
  input  logic [1:0]             OP,
  input  logic [4*NIBBLES-1:0]   A,
  input  logic [4*NIBBLES-1:0]   B,
  input  logic                   CIN,
  output logic [3:0]             MR,
  output logic [3:0]             MS,
  output logic                   CI,
  output logic [2:0]             ALB_MI,
  input  logic [3:0]             F_ALB,
  input  logic                   CO,
  input  logic                   VO,
  input  logic                   NO,
  input  logic                   ZO,
  output logic [4*NIBBLES-1:0]   RESULT,
  output logic                   C_FLAG,
  output logic                   V_FLAG,
  output logic                   N_FLAG,
  output logic                   Z_FLAG,
  output logic                   BUSY,
  output logic                   DONE
);

  localparam int W  = 4 * NIBBLES;
  localparam int KW = $clog2(NIBBLES);
  localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_FIN} state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0]  a_lat_q, a_lat_d, b_lat_q, b_lat_d;
  logic [1:0]    op_q, op_d;
  logic          cin_q, cin_d, carry_q, carry_d, zero_q, zero_d;
  logic [W-1:0]  shadow_q, shadow_d, result_q, result_d;
  logic          c_q, c_d, v_q, v_d, n_q, n_d, z_q, z_d;
  logic          arith;

  // The sign flag is taken from F_ALB[3]; the ALB's NO output carries the same bit.
  logic unused_no;
  assign unused_no = NO;

  // add (11) and sub (00) chain carry; and/or do not
  assign arith = (op_q[1] == op_q[0]);

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    a_lat_d  = a_lat_q;
    b_lat_d  = b_lat_q;
    op_d     = op_q;
    cin_d    = cin_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    shadow_d = shadow_q;
    result_d = result_q;
    c_d      = c_q;
    v_d      = v_q;
    n_d      = n_q;
    z_d      = z_q;
    MR       = 4'h0;
    MS       = 4'h0;
    CI       = 1'b0;
    ALB_MI   = 3'b111;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          a_lat_d = A;
          b_lat_d = B;
          op_d    = OP;
          cin_d   = CIN;
          zero_d  = 1'b1;
          k_d     = '0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        MR     = a_lat_q[4*k_q +: 4];
        MS     = b_lat_q[4*k_q +: 4];
        ALB_MI = {1'b0, op_q};
        CI     = arith & ((k_q == '0) ? cin_q : carry_q);
        shadow_d[4*k_q +: 4] = F_ALB;
        carry_d = CO;
        zero_d  = zero_q & ZO;
        if (k_q == K_LAST) begin
          // Top nibble: publish the word result and flags so they are visible in FIN.
          result_d = shadow_d;
          c_d      = arith & CO;
          v_d      = arith & VO;
          n_d      = F_ALB[3];
          z_d      = zero_q & ZO;
          state_d  = S_FIN;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      a_lat_q  <= '0;
      b_lat_q  <= '0;
      op_q     <= '0;
      cin_q    <= 1'b0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      shadow_q <= '0;
      result_q <= '0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      a_lat_q  <= a_lat_d;
      b_lat_q  <= b_lat_d;
      op_q     <= op_d;
      cin_q    <= cin_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      shadow_q <= shadow_d;
      result_q <= result_d;
      c_q      <= c_d;
      v_q      <= v_d;
      n_q      <= n_d;
      z_q      <= z_d;
    end
  end

  assign RESULT = result_q;
  assign C_FLAG = c_q;
  assign V_FLAG = v_q;
  assign N_FLAG = n_q;
  assign Z_FLAG = z_q;
  assign BUSY   = (state_q == S_EXEC);
  assign DONE   = (state_q == S_FIN);

endmodule

// File: tb/tb_alb_nibble_sequencer.sv
// Bench for alb_nibble_sequencer: a behavioural 4-bit ALB closes the loop, directed
// vectors carry hand-computed results, plus sequences for ignored START and async reset.
module tb_alb_nibble_sequencer;

  localparam logic [1:0] OP_SUB = 2'b00, OP_AND = 2'b01, OP_OR = 2'b10, OP_ADD = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = '0;
  logic [15:0] a = '0, b = '0;
  logic        cin = 1'b0;
  logic [3:0]  mr, ms, f_alb;
  logic        ci, co, vo, no_o, zo;
  logic [2:0]  alb_mi;
  logic [15:0] result;
  logic        c_flag, v_flag, n_flag, z_flag, busy, done;

  int n_vec = 0;
  int n_err = 0;

  alb_nibble_sequencer #(.NIBBLES(4)) dut (
    .CLK(clk), .RST(rst), .START(start), .OP(op), .A(a), .B(b), .CIN(cin),
    .MR(mr), .MS(ms), .CI(ci), .ALB_MI(alb_mi),
    .F_ALB(f_alb), .CO(co), .VO(vo), .NO(no_o), .ZO(zo),
    .RESULT(result), .C_FLAG(c_flag), .V_FLAG(v_flag), .N_FLAG(n_flag), .Z_FLAG(z_flag),
    .BUSY(busy), .DONE(done)
  );

  always #5 clk = ~clk;

  // Behavioural ALB: sub is MR + ~MS + CI, opcodes 1xx drive all outputs low.
  logic [4:0] alb_sum;
  logic [3:0] alb_bb;
  always_comb begin
    alb_sum = '0;
    alb_bb  = mr;
    f_alb   = '0;
    co      = 1'b0;
    vo      = 1'b0;
    case (alb_mi)
      3'b011: begin alb_bb = ms;  alb_sum = {1'b0, mr} + {1'b0, ms}  + {4'b0, ci}; end
      3'b000: begin alb_bb = ~ms; alb_sum = {1'b0, mr} + {1'b0, ~ms} + {4'b0, ci}; end
      3'b001: alb_sum = {1'b0, mr & ms};
      3'b010: alb_sum = {1'b0, mr | ms};
      default: alb_sum = '0;
    endcase
    f_alb = alb_sum[3:0];
    if (alb_mi == 3'b011 || alb_mi == 3'b000) begin
      co = alb_sum[4];
      vo = (mr[3] == alb_bb[3]) && (f_alb[3] != mr[3]);
    end
  end
  assign no_o = f_alb[3];
  assign zo   = (f_alb == 4'h0) && !alb_mi[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One complete operation at fixed latency; operands are scrambled right after START.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] xa,
                        input logic [15:0] xb, input logic xc, input logic [15:0] e_res,
                        input logic [3:0] e_flags, input logic [3:0] e_ci);
    logic [15:0] mr_all, ms_all;
    logic [11:0] mi_all;
    logic [3:0]  ci_all, busy_all, done_all;
    @(negedge clk);
    op = o; a = xa; b = xb; cin = xc; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 16'($urandom_range(0, 65535));
    b = 16'($urandom_range(0, 65535));
    op = 2'($urandom_range(0, 3));
    cin = 1'($urandom_range(0, 1));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      mr_all[4*k +: 4] = mr;
      ms_all[4*k +: 4] = ms;
      mi_all[3*k +: 3] = alb_mi;
      ci_all[k]   = ci;
      busy_all[k] = busy;
      done_all[k] = done;
    end
    chk({tag, " mr_seq"}, 32'(mr_all), 32'(xa));
    chk({tag, " ms_seq"}, 32'(ms_all), 32'(xb));
    chk({tag, " mi_seq"}, 32'(mi_all), 32'({4{1'b0, o}}));
    chk({tag, " ci_seq"}, 32'(ci_all), 32'(e_ci));
    chk({tag, " busy_done_exec"}, 32'({busy_all, done_all}), 32'h0000_00F0);
    @(negedge clk);
    chk({tag, " done_busy_fin"}, 32'({done, busy}), 32'h2);
    chk({tag, " result"}, 32'(result), 32'(e_res));
    chk({tag, " flags_cvnz"}, 32'({c_flag, v_flag, n_flag, z_flag}), 32'(e_flags));
    chk({tag, " bus_idle_fin"}, 32'({mr, ms, ci, alb_mi}), 32'h0007);
    @(negedge clk);
    chk({tag, " done_drop"}, 32'(done), 32'h0);
    chk({tag, " result_hold"}, 32'(result), 32'(e_res));
  endtask

  typedef struct {
    string       tag;
    logic [1:0]  op;
    logic [15:0] a, b;
    logic        cin;
    logic [15:0] res;
    logic [3:0]  flags;  // {C,V,N,Z}
    logic [3:0]  ci;     // CI seen in nibble k at bit k
  } vec_t;

  vec_t vecs[8];

  initial begin
    int dones;
    vecs[0] = '{"add_00ff_1",   OP_ADD, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 4'b0000, 4'b0110};
    vecs[1] = '{"sub_1000_1",   OP_SUB, 16'h1000, 16'h0001, 1'b1, 16'h0FFF, 4'b1000, 4'b0001};
    vecs[2] = '{"add_ffff_1",   OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 4'b1001, 4'b1110};
    vecs[3] = '{"and_f0f0",     OP_AND, 16'hF0F0, 16'h0FF0, 1'b1, 16'h00F0, 4'b0000, 4'b0000};
    vecs[4] = '{"or_f0f0",      OP_OR,  16'hF0F0, 16'h0FF0, 1'b1, 16'hFFF0, 4'b0010, 4'b0000};
    vecs[5] = '{"add_ovf",      OP_ADD, 16'h7000, 16'h1000, 1'b0, 16'h8000, 4'b0110, 4'b0000};
    vecs[6] = '{"sub_equal",    OP_SUB, 16'h0005, 16'h0005, 1'b1, 16'h0000, 4'b1001, 4'b1111};
    vecs[7] = '{"sub_borrow",   OP_SUB, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 4'b0010, 4'b0000};

    #1;
    chk("reset_outputs", 32'({result, c_flag, v_flag, n_flag, z_flag, busy, done}), 32'h0);
    chk("reset_bus", 32'({mr, ms, ci, alb_mi}), 32'h0007);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].tag, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin,
             vecs[i].res, vecs[i].flags, vecs[i].ci);

    // START during EXEC (cycle 2) and FIN (cycle 5) is dropped; START in the next IDLE is taken.
    dones = 0;
    @(negedge clk);
    op = OP_ADD; a = 16'h0010; b = 16'h0020; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (done) dones++;
      if (c == 2 || c == 5) begin
        op = OP_OR; a = 16'hF0F0; b = 16'h0FF0; start = 1'b1;
        @(posedge clk);
        #1 if (c == 2) start = 1'b0;
      end
    end
    @(negedge clk);
    chk("ign_busy_after_fin", 32'({busy, done}), 32'h0);
    chk("ign_result", 32'(result), 32'h0030);
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 7; c <= 10; c++) begin
      @(negedge clk);
      if (done) dones++;
      chk("idle_start_busy", 32'(busy), 32'h1);
    end
    chk("ign_single_done", 32'(dones), 32'h1);
    @(negedge clk);
    chk("idle_start_done", 32'(done), 32'h1);
    chk("idle_start_result", 32'(result), 32'hFFF0);
    @(negedge clk);

    // Asynchronous reset in nibble k=2 of an ADD.
    @(negedge clk);
    op = OP_ADD; a = 16'h00FF; b = 16'h0001; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_outputs", 32'({result, c_flag, v_flag, n_flag, z_flag, busy, done}), 32'h0);
    chk("rst_mid_bus", 32'({mr, ms, ci, alb_mi}), 32'h0007);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    chk("rst_no_done", 32'(dones), 32'h0);
    run_op("add_3_4", OP_ADD, 16'h0003, 16'h0004, 1'b0, 16'h0007, 4'b0000, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alb_nibble_sequencer.md
Name: alb_nibble_sequencer

Overview:
Multi-nibble initiator for the 4-bit ALB. It accepts one wide operation (default 16 bit) and issues it to the combinational ALB one nibble per clock, LSB first. It chains carry between nibbles, captures each F_ALB nibble, and folds the per-nibble flags into whole-word C/V/N/Z. It sits between the control/microprogram layer and the ALB, driving MR/MS/CI/ALB_MI and consuming F_ALB/CO/VO/NO/ZO.

Parameters:
NIBBLES, 4, number of 4-bit slices per operation; operand width W = 4*NIBBLES (minimum 2).

Ports:
CLK  in  1  system clock, rising edge.
RST  in  1  asynchronous, active-high reset.
START  in  1  request; sampled only in IDLE.
OP  in  2  operation: 00 sub (A-B-1+CIN), 01 and, 10 or, 11 add; equals ALB_MI[1:0] encoding.
A  in  W  first operand (maps to MR).
B  in  W  second operand (maps to MS).
CIN  in  1  carry-in for nibble 0 (add/sub only).
MR  out  4  ALB operand nibble.
MS  out  4  ALB operand nibble.
CI  out  1  ALB carry-in.
ALB_MI  out  3  ALB opcode.
F_ALB  in  4  ALB result nibble.
CO  in  1  ALB carry-out.
VO  in  1  ALB overflow.
NO  in  1  ALB sign (unused except via F_ALB[3]).
ZO  in  1  ALB zero.
RESULT  out  W  word result; updated only on completion.
C_FLAG, V_FLAG, N_FLAG, Z_FLAG  out  1 each  word flags; updated only on completion.
BUSY  out  1  high while an operation is in flight.
DONE  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, any state): state IDLE, nibble counter 0, RESULT=0, all flags 0, BUSY=0, DONE=0, internal operand/carry regs 0.
- Bus outputs are registered-state-driven combinational. In IDLE/FIN: MR=0, MS=0, CI=0, ALB_MI=3'b111 (ALB outputs 0).
- FSM IDLE -> EXEC -> FIN -> IDLE.
- IDLE: START=1 latches A, B, OP, CIN; counter k=0; go to EXEC. BUSY=1 from the next cycle.
- EXEC, nibble k, one cycle per nibble:
  - MR=A_lat[4k+3:4k], MS=B_lat[4k+3:4k], ALB_MI={1'b0,OP_lat}.
  - CI: for add/sub, CIN_lat at k=0, else the registered CO of nibble k-1. For and/or, CI=0.
  - At the clock edge: store F_ALB into shadow[4k+3:4k], register CO as the chain carry, and AND ZO into a running zero (initialised 1 at START).
  - When k=NIBBLES-1, also capture CO, VO and F_ALB[3] of the top nibble, then go to FIN. Otherwise k++.
- FIN, one cycle:
  - RESULT=shadow, C_FLAG=top CO, V_FLAG=top VO, N_FLAG=top F_ALB[3], Z_FLAG=running zero.
  - For and/or, C_FLAG=V_FLAG=0.
  - DONE=1, BUSY=0. Next state is IDLE.
- Latency: START sampled at edge 0. Nibbles execute in cycles 1..NIBBLES. RESULT, flags and DONE are valid in cycle NIBBLES+1 (cycle 5 for default). Issue rate is one operation per NIBBLES+2 cycles.
- START while BUSY or in FIN is ignored, not queued. Operand changes after START have no effect.
- RESULT and flags hold their last completed values until the next FIN.
- Reset mid-operation aborts immediately: no DONE pulse, RESULT and flags cleared to 0.
- The counter must not wrap. EXEC exits exactly after nibble NIBBLES-1.

Test Plan:
- ADD A=0x00FF, B=0x0001, CIN=0 -> cycles 1..4 show ALB_MI=011 and MR=F,F,0,0; CI=0,1,1,0. Cycle 5: RESULT=0x0100, C=0, N=0, Z=0, DONE=1 for exactly one cycle.
- SUB A=0x1000, B=0x0001, CIN=1 -> ALB_MI=000, CI=1,0,0,0; RESULT=0x0FFF, C=1, N=0, Z=0.
- ADD A=0xFFFF, B=0x0001, CIN=0 -> RESULT=0x0000, C=1, Z=1, N=0.
- AND A=0xF0F0, B=0x0FF0 -> RESULT=0x00F0, C=0, V=0, Z=0, CI=0 all cycles. OR with the same operands -> RESULT=0xFFF0, N=1.
- START pulsed again in cycles 2 and 5 of an ADD -> ignored, only one DONE. A START in the first IDLE cycle after FIN is accepted.
- RST asserted asynchronously mid-EXEC (k=2) of an ADD -> BUSY=0, DONE=0, RESULT=0 immediately. After release, a new ADD 0x0003+0x0004 gives RESULT=0x0007.
